imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the immediate extender: takes a 64-bit sign-extended immediate, an immsrc format code and the non-immediate instruction fields, and packs them into a 32-bit RV instruction word.
- Range- and alignment-checks the immediate.
- Used by the self-test instruction generator and the assembler-in-the-loop testbench to build instruction streams that the single-cycle core decodes.
- Two-stage valid/ready pipeline with backpressure, plus saturating statistics counters.

Parameters:
- CNT_W, 16, width of the encoded-instruction and error counters.
- DROP_ON_ERR, 0: when 1, instructions failing the check are consumed but not emitted; when 0 they are emitted with out_err=1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  encoder can accept the input this cycle.
- immsrc  in  2  00 I-type, 01 S-type, 10 B-type, 11 J-type.
- imm  in  64  sign-extended immediate value (byte offset for B/J).
- opcode  in  7  instr[6:0].
- rd  in  5  destination register; used for I and J only.
- funct3  in  3  instr[14:12]; used for I, S and B only.
- rs1  in  5  instr[19:15]; used for I, S and B only.
- rs2  in  5  instr[24:20]; used for S and B only.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output.
- out_instr  out  32  packed instruction.
- out_err  out  2  00 ok, 01 out of range, 10 misaligned (bit0 set on B/J), 11 both.
- cnt_clr  in  1  synchronous clear of both counters.
- enc_cnt  out  CNT_W  number of instructions emitted without error, saturating.
- err_cnt  out  CNT_W  number of inputs accepted with out_err!=0, saturating; counted whether or not dropped.

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_instr=0, out_err=0, enc_cnt=0, err_cnt=0. in_ready=1 after reset.
- Reset mid-operation discards all in-flight transactions; nothing held is emitted after release.
- Handshake: a transfer occurs on a clock edge where valid and ready are both high. While out_valid=1 and out_ready=0, out_instr and out_err hold stable. in_ready is a combinational function of pipeline state and out_ready only, with no dependence on in_valid.
- Stage 1 (S1) registers the inputs and computes err on accept.
- Stage 1 range rules, signed, on the full 64 bits:
  - I and S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and imm[0]==0.
  - J: imm must lie in [-1048576, 1048574] and imm[0]==0.
  - Out-of-range means the bits above the field MSB are not all equal to the field MSB.
- Stage 2 (S2) registers the packed word:
  - I: instr[31:20]=imm[11:0]; rs1, funct3, rd, opcode in the standard positions.
  - S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; rs2, rs1, funct3, opcode.
  - B: instr[31]=imm[12], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1], instr[7]=imm[11]; rs2, rs1, funct3, opcode.
  - J: instr[31]=imm[20], instr[30:21]=imm[10:1], instr[20]=imm[11], instr[19:12]=imm[19:12]; rd, opcode.
  - On error, the word is packed from the truncated immediate bits anyway.
- Pipeline advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Latency is 2 cycles from input accept to out_valid. Full throughput is 1 per cycle with out_ready held high.
  - A 2-deep backpressure stall holds both entries and deasserts in_ready.
- DROP_ON_ERR=1: an S1 entry with err!=0 advances into S2 as a bubble (s2_valid=0) and still increments err_cnt.
- Counters update on the S1 to S2 advance: enc_cnt increments on ok, err_cnt increments on err!=0. Both stick at 2^CNT_W-1. If cnt_clr and an increment occur in the same cycle, the clear wins and the counter becomes 0.
- Round-trip invariant: for err==0, sign-extending out_instr with the matching immsrc reproduces imm exactly.

Test Plan:
- Reset with valid traffic in flight -> out_valid=0 immediately (async); counters 0; after release the first output corresponds to the first post-reset accept.
- I-type: imm=-1, rs1=5, rd=10, funct3=0, opcode=0x13 -> out_instr=0xFFF28513, err=00, 2 cycles after accept. S-type: imm=8, rs2=6, rs1=2, funct3=3, opcode=0x23 -> 0x00613423.
- B-type imm=-4 with rs1=rs2=0, opcode=0x63 -> 0xFE000EE3. B-type imm=3 -> err=10. J-type imm=0x100000 (1048576) -> err=01. J-type imm=2048, rd=1, opcode=0x6F -> 0x001000EF.
- Backpressure: stream 4 inputs, hold out_ready=0 for 5 cycles -> in_ready low after 2 accepts, out_instr stable, then in-order delivery with no loss or duplication.
- Counters: CNT_W=4, 20 ok inputs -> enc_cnt=15 saturated; cnt_clr coincident with an increment -> 0. DROP_ON_ERR=1 with an error input -> no output emitted, err_cnt=1.
- Random 10k mixed formats -> round-trip invariant holds for every err==0 output; err matches the reference range model.

Source files
------------

// File: rtl/imm_encoder_if.sv
// imm_encoder_if: handshake and field bundle between an instruction generator and imm_encoder
// master: drives the input transaction, out_ready and cnt_clr; observes outputs and counters
// slave : the encoder side
interface imm_encoder_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       immsrc;
  logic [63:0]      imm;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [1:0]       out_err;
  logic             cnt_clr;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;
  modport master (
    output in_valid, immsrc, imm, opcode, rd, funct3, rs1, rs2, out_ready, cnt_clr,
    input  in_ready, out_valid, out_instr, out_err, enc_cnt, err_cnt
  );
  modport slave (
    input  in_valid, immsrc, imm, opcode, rd, funct3, rs1, rs2, out_ready, cnt_clr,
    output in_ready, out_valid, out_instr, out_err, enc_cnt, err_cnt
  );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: packs a sign-extended immediate plus register fields into an RV instruction word
// clk   : rising-edge clock
// reset : asynchronous active-high reset
// bus   : imm_encoder_if.slave (input transaction, output word/err, counter clear and counters)
module imm_encoder #(
  parameter int CNT_W       = 16,
  parameter bit DROP_ON_ERR = 0
) (
  input logic           clk,
  input logic           reset,
  imm_encoder_if.slave  bus
);
  logic             r_s1_valid, r_s2_valid;
  logic [1:0]       r_s1_src, r_s1_err, r_s2_err;
  logic [20:0]      r_s1_imm;
  logic [6:0]       r_s1_op;
  logic [4:0]       r_s1_rd, r_s1_rs1, r_s1_rs2;
  logic [2:0]       r_s1_f3;
  logic [31:0]      r_s2_instr;
  logic [CNT_W-1:0] r_enc, r_err;
  logic             w_s2_adv, w_s1_adv, w_mv, w_ok11, w_ok12, w_ok20, w_oor;
  logic             w_inc_e, w_inc_r;
  logic [1:0]       w_err;
  logic [31:0]      w_instr;
  assign w_s2_adv = !r_s2_valid || bus.out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_mv     = r_s1_valid && w_s2_adv;
  // in range when every bit above the field MSB matches the field MSB
  assign w_ok11 = &bus.imm[63:11] || ~|bus.imm[63:11];
  assign w_ok12 = &bus.imm[63:12] || ~|bus.imm[63:12];
  assign w_ok20 = &bus.imm[63:20] || ~|bus.imm[63:20];
  assign w_oor  = bus.immsrc[1] ? (bus.immsrc[0] ? !w_ok20 : !w_ok12) : !w_ok11;
  assign w_err  = {bus.immsrc[1] & bus.imm[0], w_oor};
  always_comb begin
    w_instr = r_s1_src == 2'b00 ? {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op}
            : r_s1_src == 2'b01 ? {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op}
            : r_s1_src == 2'b10 ? {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                                   r_s1_imm[4:1], r_s1_imm[11], r_s1_op}
            : {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12], r_s1_rd, r_s1_op};
  end
  assign w_inc_e = w_mv && r_s1_err == 2'b00 && !(&r_enc);
  assign w_inc_r = w_mv && r_s1_err != 2'b00 && !(&r_err);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_src   <= '0;
      r_s1_err   <= '0;
      r_s1_imm   <= '0;
      r_s1_op    <= '0;
      r_s1_rd    <= '0;
      r_s1_f3    <= '0;
      r_s1_rs1   <= '0;
      r_s1_rs2   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_src <= bus.immsrc;
        r_s1_err <= w_err;
        r_s1_imm <= bus.imm[20:0];
        r_s1_op  <= bus.opcode;
        r_s1_rd  <= bus.rd;
        r_s1_f3  <= bus.funct3;
        r_s1_rs1 <= bus.rs1;
        r_s1_rs2 <= bus.rs2;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= '0;
      r_s2_err   <= '0;
    end else if (w_s2_adv) begin
      // with DROP_ON_ERR a failing entry still leaves S1 but enters S2 as a bubble
      r_s2_valid <= r_s1_valid && !(DROP_ON_ERR && r_s1_err != 2'b00);
      if (r_s1_valid) begin
        r_s2_instr <= w_instr;
        r_s2_err   <= r_s1_err;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enc <= '0;
      r_err <= '0;
    end else begin
      r_enc <= bus.cnt_clr ? '0 : r_enc + CNT_W'(w_inc_e);
      r_err <= bus.cnt_clr ? '0 : r_err + CNT_W'(w_inc_r);
    end
  end
  assign bus.in_ready  = w_s1_adv;
  assign bus.out_valid = r_s2_valid;
  assign bus.out_instr = r_s2_instr;
  assign bus.out_err   = r_s2_err;
  assign bus.enc_cnt   = r_enc;
  assign bus.err_cnt   = r_err;
endmodule
